// File: rtl/wr_router.sv
// Single-outstanding write router: one master burst at a time is steered to the slave
// selected by address bits [30:28]; out-of-range indices are sunk locally and answered with DECERR.
module wr_router #(
  parameter int num_slaves = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                m_awaddr,
  input  logic [7:0]                 m_awlen,
  input  logic                       m_awvalid,
  output logic                       m_awready,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  input  logic                       m_wlast,
  input  logic                       m_wvalid,
  output logic                       m_wready,
  output logic [1:0]                 m_bresp,
  output logic                       m_bvalid,
  input  logic                       m_bready,
  output logic [31:0]                s_awaddr,
  output logic [7:0]                 s_awlen,
  output logic [num_slaves-1:0]      s_awvalid,
  input  logic [num_slaves-1:0]      s_awready,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  output logic                       s_wlast,
  output logic [num_slaves-1:0]      s_wvalid,
  input  logic [num_slaves-1:0]      s_wready,
  input  logic [num_slaves-1:0][1:0] s_bresp,
  input  logic [num_slaves-1:0]      s_bvalid,
  output logic [num_slaves-1:0]      s_bready,
  output logic [2:0]                 aw_sel_q
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;
  localparam logic [3:0] NumSlaves = 4'(num_slaves);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  aw_sel_d;
  logic        dec_err_q, dec_err_d;
  logic        len_err_q, len_err_d;

  logic [num_slaves-1:0] sel_oh;
  logic [1:0]            sel_bresp;
  logic                  sel_awready, sel_wready, sel_bvalid;
  logic                  last_expected;

  always_comb begin
    sel_oh    = '0;
    sel_bresp = 2'b00;
    for (int i = 0; i < num_slaves; i++) begin
      if (aw_sel_q == 3'(i)) begin
        sel_oh[i] = 1'b1;
        sel_bresp = s_bresp[i];
      end else begin
        sel_oh[i] = 1'b0;
      end
    end
    sel_awready = |(s_awready & sel_oh);
    sel_wready  = |(s_wready & sel_oh);
    sel_bvalid  = |(s_bvalid & sel_oh);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    aw_sel_d  = aw_sel_q;
    dec_err_d = dec_err_q;
    len_err_d = len_err_q;
    cnt_d     = cnt_q;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    // comparing before the increment lets len=255 check its 256th beat without wrapping
    last_expected = (cnt_q == len_q);
    case (state_q)
      IDLE: begin
        m_awready = 1'b1;
        if (m_awvalid) begin
          addr_d    = m_awaddr;
          len_d     = m_awlen;
          aw_sel_d  = m_awaddr[30:28];
          dec_err_d = ({1'b0, m_awaddr[30:28]} >= NumSlaves);
          len_err_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = dec_err_d ? DATA : ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        s_awvalid = sel_oh;
        state_d   = sel_awready ? DATA : ADDR;
      end
      DATA: begin
        if (dec_err_q) begin
          m_wready = 1'b1;
        end else begin
          m_wready = sel_wready;
          s_wvalid = sel_oh & {num_slaves{m_wvalid}};
        end
        if (m_wvalid && m_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (m_wlast != last_expected) begin
            len_err_d = 1'b1;
          end else begin
            len_err_d = len_err_q;
          end
          state_d = m_wlast ? RESP : DATA;
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        if (dec_err_q) begin
          m_bvalid = 1'b1;
          m_bresp  = 2'b11;
        end else begin
          m_bvalid = sel_bvalid;
          s_bready = sel_oh & {num_slaves{m_bready}};
          m_bresp  = (len_err_q && (sel_bresp == 2'b00)) ? 2'b10 : sel_bresp;
        end
        state_d = (m_bvalid && m_bready) ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bvalid  = 1'b0;
      m_bresp   = 2'b00;
      s_awvalid = '0;
      s_wvalid  = '0;
      s_bready  = '0;
    end else begin
      m_awready = m_awready;
    end
  end

  assign s_awaddr = rst ? 32'd0 : addr_q;
  assign s_awlen  = rst ? 8'd0  : len_q;
  assign s_wdata  = rst ? 32'd0 : m_wdata;
  assign s_wstrb  = rst ? 4'd0  : m_wstrb;
  assign s_wlast  = rst ? 1'b0  : m_wlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      aw_sel_q  <= 3'd0;
      dec_err_q <= 1'b0;
      len_err_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      aw_sel_q  <= aw_sel_d;
      dec_err_q <= dec_err_d;
      len_err_q <= len_err_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_wr_router.sv
// Self-checking bench for wr_router: scoreboard queues for W beats and B responses,
// checked by a negedge monitor; scenario tasks check routing, errors, stalls and reset.
module tb_wr_router;
  localparam int NS = 5;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic m_wlast, m_wvalid, m_wready;
  logic [1:0] m_bresp;
  logic m_bvalid, m_bready;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [NS-1:0] s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic s_wlast;
  logic [NS-1:0] s_wvalid, s_wready;
  logic [NS-1:0][1:0] s_bresp;
  logic [NS-1:0] s_bvalid, s_bready;
  logic [2:0] aw_sel_q;

  always #5 clk = ~clk;

  wr_router #(.num_slaves(NS)) dut (
    .clk(clk), .rst(rst),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready), .aw_sel_q(aw_sel_q)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } beat_t;

  int n_cmp = 0;
  int n_fail = 0;
  beat_t wq[$];
  logic [1:0] bq[$];
  logic [NS-1:0] exp_mask = '0;
  logic [31:0] exp_addr = 32'd0;
  logic [7:0]  exp_len = 8'd0;
  int beats_at[NS];
  int awv_cyc[NS];
  logic [1:0] slave_resp[NS];
  bit stall_en = 1'b0;
  bit aw_hold = 1'b0;
  logic [99:0] all_outs;

  assign all_outs = {m_awready, m_wready, m_bvalid, m_bresp, s_awaddr, s_awlen, s_awvalid,
                     s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready, aw_sel_q};
  assign s_awready = aw_hold ? '0 : '1;

  always_comb begin
    for (int i = 0; i < NS; i++) s_bresp[i] = slave_resp[i];
  end

  // slave-side ready/valid, optionally randomly stalled
  initial begin
    s_wready = '1;
    s_bvalid = '1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        s_wready = NS'($urandom);
        s_bvalid = NS'($urandom);
      end else begin
        s_wready = '1;
        s_bvalid = '1;
      end
    end
  end

  // monitor: slave-side handshakes and master B handshake against the scoreboard
  initial begin
    beat_t bt;
    logic [1:0] eb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < NS; i++) if (s_awvalid[i]) awv_cyc[i]++;
        if (s_awvalid != '0) begin
          n_cmp++;
          if (s_awvalid !== exp_mask || s_awaddr !== exp_addr || s_awlen !== exp_len) begin
            n_fail++;
            $display("FAIL aw_route: got valid=%b addr=%h len=%0d, want valid=%b addr=%h len=%0d",
                     s_awvalid, s_awaddr, s_awlen, exp_mask, exp_addr, exp_len);
          end
        end
        if ((s_wvalid | s_bready) != '0) begin
          n_cmp++;
          if (((s_wvalid | s_bready) & ~exp_mask) != '0) begin
            n_fail++;
            $display("FAIL slave_select: got wvalid=%b bready=%b, allowed mask=%b", s_wvalid, s_bready, exp_mask);
          end
        end
        if ((s_wvalid & s_wready) != '0) begin
          n_cmp++;
          if (wq.size() == 0) begin
            n_fail++;
            $display("FAIL w_unexpected: got beat %h at slaves %b, want no beat", s_wdata, s_wvalid & s_wready);
          end else begin
            bt = wq.pop_front();
            for (int i = 0; i < NS; i++) if (s_wvalid[i] && s_wready[i]) beats_at[i]++;
            if ({s_wdata, s_wstrb, s_wlast} !== bt) begin
              n_fail++;
              $display("FAIL w_data: got %h/%h/%b, want %h/%h/%b", s_wdata, s_wstrb, s_wlast, bt.d, bt.s, bt.l);
            end
          end
        end
        if (m_bvalid && m_bready) begin
          n_cmp++;
          if (bq.size() == 0) begin
            n_fail++;
            $display("FAIL b_unexpected: got bresp=%b, want no response", m_bresp);
          end else begin
            eb = bq.pop_front();
            if (m_bresp !== eb) begin
              n_fail++;
              $display("FAIL bresp: got %b, want %b", m_bresp, eb);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    for (int i = 0; i < NS; i++) begin
      beats_at[i] = 0;
      awv_cyc[i] = 0;
    end
  endtask

  task automatic aw_phase(input logic [31:0] a, input logic [7:0] l);
    logic [2:0] idx;
    bit hs;
    int t;
    idx = a[30:28];
    hs = 1'b0;
    t = 0;
    exp_addr = a;
    exp_len = l;
    exp_mask = (idx < 3'(NS)) ? (NS'(1) << idx) : '0;
    m_awaddr = a;
    m_awlen = l;
    m_awvalid = 1'b1;
    while (!hs && t < 200) begin
      @(negedge clk);
      hs = m_awready;
      @(posedge clk);
      #1;
      t++;
    end
    m_awvalid = 1'b0;
    n_cmp++;
    if (!hs) begin
      n_fail++;
      $display("FAIL aw_timeout: got no AW handshake in %0d cycles, want handshake", t);
    end
  endtask

  task automatic w_phase(input int nbeats, input int last_idx, input logic [31:0] base,
                         input bit sink, input bit bubbles, output int hs_cnt);
    beat_t bt;
    bit hs;
    int t;
    hs_cnt = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (bubbles) begin
        m_wvalid = 1'b0;
        while ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      bt.d = base + 32'(b);
      bt.s = 4'(b) ^ 4'hF;
      bt.l = (b == last_idx);
      m_wdata = bt.d;
      m_wstrb = bt.s;
      m_wlast = bt.l;
      m_wvalid = 1'b1;
      if (!sink) wq.push_back(bt);
      hs = 1'b0;
      t = 0;
      while (!hs && t < 200) begin
        @(negedge clk);
        hs = m_wready;
        @(posedge clk);
        #1;
        t++;
      end
      if (hs) hs_cnt++;
      else break;
    end
    m_wvalid = 1'b0;
    m_wlast = 1'b0;
    n_cmp++;
    if (hs_cnt != nbeats) begin
      n_fail++;
      $display("FAIL w_timeout: got %0d master beats accepted, want %0d", hs_cnt, nbeats);
    end
  endtask

  task automatic b_phase(input logic [1:0] e, input bit rnd);
    bit hs;
    int t;
    hs = 1'b0;
    t = 0;
    bq.push_back(e);
    while (!hs && t < 200) begin
      m_bready = rnd ? 1'($urandom) : 1'b1;
      @(negedge clk);
      hs = m_bvalid && m_bready;
      @(posedge clk);
      #1;
      t++;
    end
    m_bready = 1'b0;
    n_cmp++;
    if (!hs || bq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL b_done: got hs=%b bq=%0d wq=%0d, want hs=1 bq=0 wq=0", hs, bq.size(), wq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_awaddr = 32'h2000_0000; m_awlen = 8'd3; m_awvalid = 1'b0;
    m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF; m_wlast = 1'b1; m_wvalid = 1'b1; m_bready = 1'b1;
    for (int i = 0; i < NS; i++) slave_resp[i] = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (all_outs !== 100'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", all_outs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_wvalid = 1'b0; m_wlast = 1'b0; m_bready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_awready !== 1'b1 || aw_sel_q !== 3'd0 || m_wready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got awready=%b sel=%0d wready=%b, want 1/0/0", m_awready, aw_sel_q, m_wready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int hc;
    clear_counts();
    slave_resp[2] = 2'b00;
    aw_phase(32'h2000_0000, 8'd3);
    @(negedge clk);
    n_cmp++;
    if (aw_sel_q !== 3'd2) begin
      n_fail++;
      $display("FAIL basic_sel: got %0d, want 2", aw_sel_q);
    end
    @(posedge clk);
    #1;
    w_phase(4, 3, 32'hA000_0000, 1'b0, 1'b0, hc);
    b_phase(2'b00, 1'b0);
    n_cmp++;
    if (beats_at[2] != 4 || beats_at[0] + beats_at[1] + beats_at[3] + beats_at[4] != 0 || awv_cyc[2] < 1) begin
      n_fail++;
      $display("FAIL basic_beats: got slave2=%0d others=%0d, want 4/0",
               beats_at[2], beats_at[0] + beats_at[1] + beats_at[3] + beats_at[4]);
    end
  endtask

  task automatic test_decerr();
    int hc;
    int tot;
    clear_counts();
    aw_phase(32'h7000_0000, 8'd1);
    w_phase(2, 1, 32'hB000_0000, 1'b1, 1'b0, hc);
    b_phase(2'b11, 1'b0);
    tot = 0;
    for (int i = 0; i < NS; i++) tot += beats_at[i] + awv_cyc[i];
    n_cmp++;
    if (tot != 0 || hc != 2) begin
      n_fail++;
      $display("FAIL decerr_sink: got slave activity=%0d sunk=%0d, want 0/2", tot, hc);
    end
  endtask

  task automatic test_len_err();
    int hc;
    slave_resp[3] = 2'b00;
    aw_phase(32'h3000_0100, 8'd3);
    w_phase(2, 1, 32'hC000_0000, 1'b0, 1'b0, hc);
    b_phase(2'b10, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (m_awready !== 1'b1) begin
      n_fail++;
      $display("FAIL len_err_idle: got awready=%b, want 1", m_awready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_addr_stall();
    int hc;
    clear_counts();
    slave_resp[4] = 2'b00;
    aw_hold = 1'b1;
    m_wdata = 32'hD000_0000; m_wstrb = 4'hF; m_wlast = 1'b0; m_wvalid = 1'b1;
    aw_phase(32'h4000_0010, 8'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (m_wready !== 1'b0 || s_awvalid !== 5'b10000 || s_wvalid !== 5'b00000) begin
        n_fail++;
        $display("FAIL addr_stall: got wready=%b awvalid=%b wvalid=%b, want 0/10000/00000", m_wready, s_awvalid, s_wvalid);
      end
      @(posedge clk);
      #1;
    end
    aw_hold = 1'b0;
    w_phase(3, 2, 32'hD000_0000, 1'b0, 1'b0, hc);
    b_phase(2'b00, 1'b0);
    n_cmp++;
    if (beats_at[4] != 3) begin
      n_fail++;
      $display("FAIL addr_stall_beats: got %0d, want 3", beats_at[4]);
    end
  endtask

  task automatic test_reset_mid();
    int hc;
    clear_counts();
    aw_phase(32'h1000_0000, 8'd3);
    w_phase(2, 99, 32'hE000_0000, 1'b0, 1'b0, hc);
    m_wdata = 32'hE000_0002; m_wvalid = 1'b1; m_bready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (all_outs[99:3] !== 97'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, want 0", all_outs[99:3]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_wvalid = 1'b0; m_bready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_awready !== 1'b1 || aw_sel_q !== 3'd0 || m_bvalid !== 1'b0 || beats_at[1] != 2) begin
      n_fail++;
      $display("FAIL reset_mid_state: got awready=%b sel=%0d bvalid=%b beats=%0d, want 1/0/0/2",
               m_awready, aw_sel_q, m_bvalid, beats_at[1]);
    end
    @(posedge clk);
    #1;
    slave_resp[3] = 2'b01;
    aw_phase(32'h3000_0000, 8'd1);
    w_phase(2, 1, 32'hF000_0000, 1'b0, 1'b0, hc);
    b_phase(2'b01, 1'b0);
    n_cmp++;
    if (beats_at[3] != 2) begin
      n_fail++;
      $display("FAIL reset_mid_next: got %0d beats at slave 3, want 2", beats_at[3]);
    end
  endtask

  task automatic test_back_to_back();
    int hc;
    slave_resp[0] = 2'b01;
    slave_resp[4] = 2'b10;
    aw_phase(32'h0000_1000, 8'd0);
    w_phase(1, 0, 32'h1111_0000, 1'b0, 1'b0, hc);
    b_phase(2'b01, 1'b0);
    aw_phase(32'h4000_2000, 8'd1);
    w_phase(2, 1, 32'h2222_0000, 1'b0, 1'b0, hc);
    b_phase(2'b10, 1'b0);
  endtask

  task automatic test_long_burst();
    int hc;
    clear_counts();
    for (int i = 0; i < NS; i++) slave_resp[i] = 2'b11;
    slave_resp[0] = 2'b00;
    stall_en = 1'b1;
    aw_phase(32'h0000_0040, 8'd255);
    w_phase(256, 255, 32'h5500_0000, 1'b0, 1'b1, hc);
    b_phase(2'b00, 1'b1);
    stall_en = 1'b0;
    n_cmp++;
    if (beats_at[0] != 256) begin
      n_fail++;
      $display("FAIL long_beats: got %0d, want 256", beats_at[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decerr();
    test_len_err();
    test_addr_stall();
    test_reset_mid();
    test_back_to_back();
    test_long_burst();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
